// File: rtl/counter_seq_arbiter.sv
// counter_seq_arbiter: round-robin scheduler sharing one up/down counter between two requesters
module counter_seq_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_req_valid,
    input  logic [2*WIDTH-1:0] i_req_start,
    input  logic [1:0]         i_req_dir,
    input  logic [2*WIDTH-1:0] i_req_steps,
    output logic [1:0]         o_req_ready,
    output logic               o_cnt_rst,
    output logic               o_cnt_load,
    output logic               o_cnt_updown,
    output logic [WIDTH-1:0]   o_cnt_data,
    input  logic [WIDTH-1:0]   i_cnt_data_out,
    output logic               o_rsp_valid,
    output logic               o_rsp_id,
    output logic [WIDTH-1:0]   o_rsp_value,
    output logic               o_rsp_err,
    output logic [7:0]         o_err_count
);
    typedef enum logic [2:0] {IDLE, LOAD, COUNT, CAPTURE, RESP} state_t;
    state_t r_state, w_next;
    logic [1:0] w_grant;
    logic w_accept, w_gid, w_mis;
    logic [WIDTH-1:0] w_start, w_steps;
    logic r_last, r_id;
    logic [WIDTH-1:0] r_rem, r_exp;
    logic r_cnt_rst, r_cnt_load, r_cnt_updown;
    logic [WIDTH-1:0] r_cnt_data;
    logic r_rsp_valid, r_rsp_id, r_rsp_err;
    logic [WIDTH-1:0] r_rsp_value;
    logic [7:0] r_err_count;
    always_comb begin
        w_grant = 2'b00;
        if (r_state == IDLE && !i_rst)
            w_grant = (&i_req_valid) ? (r_last ? 2'b01 : 2'b10) : i_req_valid;
        w_accept = |w_grant;
        w_gid = w_grant[1];
        w_start = i_req_start[w_gid*WIDTH +: WIDTH];
        w_steps = i_req_steps[w_gid*WIDTH +: WIDTH];
        w_mis = i_cnt_data_out != r_exp;
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept ? LOAD : IDLE;
            LOAD:    w_next = (r_rem != '0) ? COUNT : CAPTURE;
            COUNT:   w_next = (r_rem == WIDTH'(1)) ? CAPTURE : COUNT;
            CAPTURE: w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_ff @(posedge i_clk) begin
        r_cnt_rst <= i_rst;
        if (i_rst) begin
            r_last       <= 1'b1;
            r_cnt_load   <= 1'b0;
            r_cnt_updown <= 1'b1;
            r_cnt_data   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_value  <= '0;
            r_rsp_err    <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_cnt_load  <= w_accept;
            r_rsp_valid <= r_state == CAPTURE;
            if (w_accept) begin
                r_last       <= w_gid;
                r_id         <= w_gid;
                r_rem        <= w_steps;
                r_exp        <= i_req_dir[w_gid] ? w_start + w_steps : w_start - w_steps;
                r_cnt_data   <= w_start;
                r_cnt_updown <= i_req_dir[w_gid];
            end
            if (r_state == COUNT) r_rem <= r_rem - WIDTH'(1);
            if (r_state == CAPTURE) begin
                r_rsp_id    <= r_id;
                r_rsp_value <= i_cnt_data_out;
                r_rsp_err   <= w_mis;
                if (w_mis && r_err_count != 8'd255) r_err_count <= r_err_count + 8'd1;
            end
        end
    end
    assign o_req_ready  = w_grant;
    assign o_cnt_rst    = r_cnt_rst;
    assign o_cnt_load   = r_cnt_load;
    assign o_cnt_updown = r_cnt_updown;
    assign o_cnt_data   = r_cnt_data;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_value  = r_rsp_value;
    assign o_rsp_err    = r_rsp_err;
    assign o_err_count  = r_err_count;
endmodule

// File: doc/counter_seq_arbiter.md
# counter_seq_arbiter

Round-robin scheduler that shares the single up/down counter between two requesters. Each request is a start value, a direction and a step count. The block drives the counter's reset, load, direction and data inputs, waits the requested number of counting cycles, then captures `data_out`. It returns the captured value, checked against the arithmetically expected result, and sits directly in front of the counter's control inputs.

## Interface
- `WIDTH`, 4, counter data width; step count uses the same width.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid; requester holds valid and payload until its ready bit is high.
- `req_start`  in  2×WIDTH  per-requester load value (requester i uses slice i).
- `req_dir`  in  2  per-requester direction: 1 = up, 0 = down.
- `req_steps`  in  2×WIDTH  per-requester number of count edges after load (0..2^WIDTH−1).
- `req_ready`  out  2  one-hot grant/accept, combinational.
- `cnt_rst`  out  1  to counter reset.
- `cnt_load`  out  1  to counter load.
- `cnt_updown`  out  1  to counter direction.
- `cnt_data`  out  WIDTH  to counter load data.
- `cnt_data_out`  in  WIDTH  counter value.
- `rsp_valid`  out  1  one-cycle response pulse, no backpressure.
- `rsp_id`  out  1  requester index of response.
- `rsp_value`  out  WIDTH  captured counter value.
- `rsp_err`  out  1  captured value ≠ expected.
- `err_count`  out  8  saturating mismatch count.

## Operation
- The counter behaves as follows on each edge:
  - `rst` → 0.
  - Otherwise `load` → data.
  - Otherwise +1 when updown=1, −1 when updown=0, modulo 2^WIDTH.
  - It has no enable and counts every non-load cycle.
- FSM states: IDLE, LOAD, COUNT, CAPTURE, RESP.
- IDLE:
  - `req_ready` is nonzero only in IDLE with `rst`=0.
  - Grant goes to the single valid requester. If both are valid, grant goes to the one not granted last.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On accept, latch id, start, dir and steps, and compute expected = (start ± steps) mod 2^WIDTH. Go to LOAD.
- LOAD: one cycle with `cnt_load`=1, `cnt_data`=start, `cnt_updown`=dir. Next state is COUNT if steps≠0, else CAPTURE. A remaining counter is loaded with steps.
- COUNT:
  - `cnt_load`=0.
  - Decrement remaining each cycle; leave to CAPTURE on the cycle remaining reaches 1.
  - Occupies exactly `steps` cycles.
- CAPTURE: one cycle. On its closing edge, register `cnt_data_out` into `rsp_value` and evaluate the mismatch. Go to RESP.
- RESP:
  - `rsp_valid`=1 for one cycle with id, value and err.
  - If err, `err_count` increments, saturating at 255.
  - Go to IDLE.
- Arithmetic wraps modulo 2^WIDTH: start 15, up, 1 step → 0; start 0, down, 1 step → 15.
- Outside LOAD, `cnt_data` and `cnt_updown` hold their last values and `cnt_load`=0. The counter free-runs while the block is idle; this is intended.

## Timing
- All outputs except `req_ready` are registered.
- Accept edge A: `req_valid[i]` and `req_ready[i]` are both high in the cycle before A.
  - LOAD occupies the cycle after A.
  - COUNT edges are A+2 … A+1+steps.
  - CAPTURE closes at edge A+2+steps.
  - `rsp_valid` is high in cycle A+3+steps (after edge A+2+steps).
  - The next accept is possible in the cycle after RESP.
- Throughput: one request per steps+4 cycles.
- Reset values while `rst`=1:
  - `cnt_rst`=1, `cnt_load`=0, `cnt_updown`=1, `cnt_data`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_value`=0, `rsp_err`=0, `err_count`=0.
  - `req_ready`=0, state IDLE, last-grant=1.
- `cnt_rst` is registered from `rst`: it deasserts one cycle after `rst` falls.
- Reset mid-operation aborts the transaction. No `rsp_valid` is issued, and the requester must re-present the request.
- A requester dropping `req_valid` before ready is illegal. The arbiter re-evaluates every IDLE cycle.
- Simultaneous new requests during a busy transaction are held off (`req_ready`=0) until IDLE.

## Test plan
- Reset, then requester 0 sends start=3, up, steps=5 → `cnt_load` high one cycle with data 3; `rsp_valid` at A+8; `rsp_value`=8, `rsp_err`=0, `rsp_id`=0.
- Wrap cases:
  - start=14, up, steps=3 → 1.
  - start=1, down, steps=4 → 13.
  - Both have `rsp_err`=0.
- steps=0 with start=9, down → CAPTURE directly after LOAD; `rsp_valid` at A+3; value 9.
- Both requesters valid continuously with distinct payloads → grants alternate 0,1,0,1 and `rsp_id` sequence matches; a lone requester is granted back-to-back.
- Force `cnt_data_out` to a stuck-at value (model fault) on a request expecting 6 → `rsp_err`=1, `err_count` increments by 1. Saturation check: after 256 faulty requests, `err_count` stays at 255.
- Assert `rst` for one cycle in the middle of COUNT → no `rsp_valid`; all outputs at reset values; `cnt_rst` high through the cycle after reset. A new request then completes normally.
